// File: rtl/pipe_arb_pkg.sv
// pipe_arb shared types and helpers.
// Requester index width and id type used across the arbiter slice.
package pipe_arb_pkg;

  localparam int MaxIdW = 4;

  typedef logic [MaxIdW-1:0] id_t;

  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipe_arb_pipe.sv
// Plain register pipeline for payload/id, no reset.
// Stages is at least one; stage 0 is the issue register.
module pipe_arb_pipe #(
  parameter int W      = 8,
  parameter int Stages = 1
) (
  input  logic         clk,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r [Stages];

  // Shift payload one stage per clock
  always_ff @(posedge clk) begin
    r[0] <= d;
    for (int i = 1; i < Stages; i++) begin
      r[i] <= r[i-1];
    end
  end

  assign q = r[Stages-1];

endmodule

// File: rtl/pipe_arb_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last grant.
// Produces a one-hot grant, its encoded index and an any-grant flag.
module rr_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int N   = 2,
  parameter int IdW = 1
) (
  input  logic [N-1:0]   req,
  input  logic [IdW-1:0] last,
  output logic [N-1:0]   gnt,
  output logic [IdW-1:0] idx,
  output logic           any
);

  int j;

  // First valid requester after last, wrapping modulo N
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int off = 1; off <= N; off++) begin
      j = (int'(last) + off) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IdW'(j);
      end
    end
  end

endmodule

// File: rtl/pipe_arb.sv
// Credit-gated round-robin arbiter feeding a shared fixed-latency pipe.
// Optional PIPE_ARB_CREDIT_CHECK_EN enables the sticky credit_err flag.
module pipe_arb
  import pipe_arb_pkg::*;
#(
  parameter int NumReq  = 2,
  parameter int Width   = 8,
  parameter int Depth   = 1,
  parameter int Credits = 4,
  localparam int IdW    = id_width(NumReq)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NumReq-1:0]             req_valid,
  output logic [NumReq-1:0]             req_ready,
  input  logic [NumReq-1:0][Width-1:0]  req_data,
  output logic                          out_valid,
  output logic [Width-1:0]              out_data,
  output logic [IdW-1:0]                out_id,
  input  logic                          credit_return,
  output logic                          credit_err
);

  localparam int CW = $clog2(Credits + 1);
  localparam logic [CW-1:0] Full = CW'(Credits);

  logic [CW-1:0]        count;
  logic [IdW-1:0]       last_grant;
  logic [NumReq-1:0]    gnt;
  logic [IdW-1:0]       idx;
  logic                 any;
  logic                 has_credit;
  logic                 acc;
  logic [Depth:0]       vld;
  logic [Width+IdW-1:0] pipe_q;

  rr_arbiter #(
    .N   (NumReq),
    .IdW (IdW)
  ) u_rr (
    .req  (req_valid),
    .last (last_grant),
    .gnt  (gnt),
    .idx  (idx),
    .any  (any)
  );

  assign has_credit = (count != '0) && !reset;
  assign acc        = any && has_credit;
  assign req_ready  = has_credit ? gnt : '0;

  // Credit counter: accept consumes, return refunds, saturates at Full
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= Full;
    end else if (acc && !credit_return) begin
      count <= count - 1'b1;
    end else if (!acc && credit_return && count != Full) begin
      count <= count + 1'b1;
    end
  end

  // Round-robin pointer moves only when something is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= IdW'(NumReq - 1);
    end else if (acc) begin
      last_grant <= idx;
    end
  end

  // Valid bits: issue stage plus Depth delay stages
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
    end else begin
      vld[0] <= acc;
      for (int i = 1; i <= Depth; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  pipe_arb_pipe #(
    .W      (Width + IdW),
    .Stages (Depth + 1)
  ) u_pipe (
    .clk (clk),
    .d   ({req_data[idx], idx}),
    .q   (pipe_q)
  );

  assign out_valid = vld[Depth] && !reset;
  assign out_data  = pipe_q[Width+IdW-1:IdW];
  assign out_id    = pipe_q[IdW-1:0];

`ifdef PIPE_ARB_CREDIT_CHECK_EN
  logic err_q;

  // Sticky flag for a return that would overflow the credit pool
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (credit_return && count == Full && !acc) begin
      err_q <= 1'b1;
    end
  end

  assign credit_err = err_q;
`else
  assign credit_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_arb.sv
// Scoreboard bench for pipe_arb across three parameter sets.
// Driver queues expected outputs; per-instance monitors pop and compare.
module tb_pipe_arb;
  import pipe_arb_pkg::*;

`ifdef PIPE_ARB_CREDIT_CHECK_EN
  localparam int ErrExp = 1;
`else
  localparam int ErrExp = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    id_t id;
    int  data;
    int  t;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t ea, eb, ec;

  // A: NumReq=2 Depth=1 Credits=4
  logic            a_rst, a_ov, a_cr, a_err;
  logic [1:0]      a_v, a_rdy;
  logic [1:0][7:0] a_data;
  logic [7:0]      a_od;
  logic [0:0]      a_oid;

  // B: NumReq=2 Depth=0 Credits=2
  logic            b_rst, b_ov, b_cr, b_err;
  logic [1:0]      b_v, b_rdy;
  logic [1:0][7:0] b_data;
  logic [7:0]      b_od;
  logic [0:0]      b_oid;

  // C: NumReq=4 Depth=3 Credits=4
  logic            c_rst, c_ov, c_cr, c_err;
  logic [3:0]      c_v, c_rdy;
  logic [3:0][7:0] c_data;
  logic [7:0]      c_od;
  logic [1:0]      c_oid;

  pipe_arb #(.NumReq(2), .Width(8), .Depth(1), .Credits(4)) dut_a (
    .clk(clk), .reset(a_rst), .req_valid(a_v), .req_ready(a_rdy),
    .req_data(a_data), .out_valid(a_ov), .out_data(a_od),
    .out_id(a_oid), .credit_return(a_cr), .credit_err(a_err)
  );

  pipe_arb #(.NumReq(2), .Width(8), .Depth(0), .Credits(2)) dut_b (
    .clk(clk), .reset(b_rst), .req_valid(b_v), .req_ready(b_rdy),
    .req_data(b_data), .out_valid(b_ov), .out_data(b_od),
    .out_id(b_oid), .credit_return(b_cr), .credit_err(b_err)
  );

  pipe_arb #(.NumReq(4), .Width(8), .Depth(3), .Credits(4)) dut_c (
    .clk(clk), .reset(c_rst), .req_valid(c_v), .req_ready(c_rdy),
    .req_data(c_data), .out_valid(c_ov), .out_data(c_od),
    .out_id(c_oid), .credit_return(c_cr), .credit_err(c_err)
  );

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               name, act, exp_v, cyc);
    end
  endtask

  function automatic exp_t mk(input int id, input int data, input int t);
    exp_t e;
    e.id   = id_t'(id);
    e.data = data;
    e.t    = t;
    return e;
  endfunction

  function automatic int rdy(input int s);
    case (s)
      0:       return int'(a_rdy);
      1:       return int'(b_rdy);
      default: return int'(c_rdy);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input string n, input int s, input int exp_v);
    @(negedge clk);
    chk(n, rdy(s), exp_v);
    @(posedge clk);
    #1;
  endtask

  // Monitors: compare every presented output against the queue head
  always @(negedge clk) begin
    if (a_ov) begin
      if (qa.size() == 0) chk("a_unexpected_out", 1, 0);
      else begin
        ea = qa.pop_front();
        chk("a_out_id", int'(a_oid), int'(ea.id));
        chk("a_out_data", int'(a_od), ea.data);
        chk("a_out_cycle", cyc, ea.t);
      end
    end
  end

  always @(negedge clk) begin
    if (b_ov) begin
      if (qb.size() == 0) chk("b_unexpected_out", 1, 0);
      else begin
        eb = qb.pop_front();
        chk("b_out_id", int'(b_oid), int'(eb.id));
        chk("b_out_data", int'(b_od), eb.data);
        chk("b_out_cycle", cyc, eb.t);
      end
    end
  end

  always @(negedge clk) begin
    if (c_ov) begin
      if (qc.size() == 0) chk("c_unexpected_out", 1, 0);
      else begin
        ec = qc.pop_front();
        chk("c_out_id", int'(c_oid), int'(ec.id));
        chk("c_out_data", int'(c_od), ec.data);
        chk("c_out_cycle", cyc, ec.t);
      end
    end
  end

  initial begin
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_cr = 1'b0; b_cr = 1'b0; c_cr = 1'b0;
    a_data = '0; b_data = '0; c_data = '0;
    a_v = 2'b11; b_v = 2'b01; c_v = 4'hf;
    repeat (2) step();

    // Reset state with requests pending
    @(negedge clk);
    chk("a_rst_ready", int'(a_rdy), 0);
    chk("b_rst_ready", int'(b_rdy), 0);
    chk("c_rst_ready", int'(c_rdy), 0);
    chk("a_rst_ovalid", int'(a_ov), 0);
    chk("c_rst_ovalid", int'(c_ov), 0);
    chk("a_rst_err", int'(a_err), 0);
    @(posedge clk);
    #1;
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    a_v = '0; b_v = '0; c_v = '0;
    step();

    // A: both valid, credits recycled each cycle -> 0,1,0,1...
    a_cr = 1'b1;
    a_v  = 2'b11;
    for (int k = 0; k < 8; k++) begin
      a_data[0] = 8'(8'h10 + k);
      a_data[1] = 8'(8'h20 + k);
      if (k % 2 == 1) qa.push_back(mk(1, 8'h20 + k, cyc + 2));
      else            qa.push_back(mk(0, 8'h10 + k, cyc + 2));
      tick("a_rr_ready", 0, (k % 2 == 1) ? 2 : 1);
    end

    // A: excess return at full count
    a_v = '0;
    tick("a_excess_ready", 0, 0);
    a_cr = 1'b0;
    @(negedge clk);
    chk("a_err_set", int'(a_err), ErrExp);
    repeat (3) step();
    @(negedge clk);
    chk("a_err_held", int'(a_err), ErrExp);
    @(posedge clk);
    #1;

    // A: count saturated at 4 -> exactly 4 accepts
    a_v = 2'b01;
    for (int k = 0; k < 6; k++) begin
      a_data[0] = 8'(8'h40 + k);
      if (k < 4) qa.push_back(mk(0, 8'h40 + k, cyc + 2));
      tick("a_sat_ready", 0, (k < 4) ? 1 : 0);
    end
    a_v = '0;
    repeat (3) step();
    a_rst = 1'b1;
    step();
    a_rst = 1'b0;
    @(negedge clk);
    chk("a_err_cleared", int'(a_err), 0);
    @(posedge clk);
    #1;

    // B: two credits, no returns -> two accepts then stall
    b_v = 2'b01;
    for (int k = 0; k < 5; k++) begin
      b_data[0] = 8'(8'h50 + k);
      if (k < 2) qb.push_back(mk(0, 8'h50 + k, cyc + 1));
      tick("b_starve_ready", 1, (k < 2) ? 1 : 0);
    end

    // B: return at zero count does not enable same-cycle accept
    b_cr = 1'b1;
    b_data[0] = 8'h66;
    tick("b_ret_same_ready", 1, 0);
    b_cr = 1'b0;
    qb.push_back(mk(0, 8'h66, cyc + 1));
    tick("b_ret_next_ready", 1, 1);
    tick("b_ret_after_ready", 1, 0);

    // B: Depth=0 single accepts, one cycle latency
    b_v = '0;
    b_cr = 1'b1;
    repeat (2) step();
    b_cr = 1'b0;
    b_v = 2'b01;
    b_data[0] = 8'hA5;
    qb.push_back(mk(0, 8'hA5, cyc + 1));
    tick("b_a5_ready", 1, 1);
    b_v = 2'b10;
    b_data[1] = 8'h3C;
    qb.push_back(mk(1, 8'h3C, cyc + 1));
    tick("b_req1_ready", 1, 2);
    b_v = '0;
    @(negedge clk);
    chk("b_err", int'(b_err), 0);
    @(posedge clk);
    #1;

    // C: wrap search from 3 over {0,1,3}, then reset flushes in-flight
    c_v = 4'b1011;
    for (int i = 0; i < 4; i++) c_data[i] = 8'(i + 1);
    tick("c_rr0_ready", 2, 1);
    tick("c_rr1_ready", 2, 2);
    tick("c_rr3_ready", 2, 8);
    c_rst = 1'b1;
    @(negedge clk);
    chk("c_midrst_ready", int'(c_rdy), 0);
    chk("c_midrst_ovalid", int'(c_ov), 0);
    @(posedge clk);
    #1;
    c_rst = 1'b0;
    c_v = '0;
    repeat (6) step();

    // C: count back at 4 after reset
    c_v = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      c_data[0] = 8'(8'h70 + k);
      if (k < 4) qc.push_back(mk(0, 8'h70 + k, cyc + 4));
      tick("c_full_ready", 2, (k < 4) ? 1 : 0);
    end
    c_v = '0;
    c_cr = 1'b1;
    step();
    c_cr = 1'b0;
    c_v = 4'b0100;
    c_data[2] = 8'h99;
    qc.push_back(mk(2, 8'h99, cyc + 4));
    tick("c_ret_ready", 2, 4);
    c_v = '0;

    repeat (8) step();
    chk("a_pending", qa.size(), 0);
    chk("b_pending", qb.size(), 0);
    chk("c_pending", qc.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
